// File: rtl/bypass_ctrl_if.sv
// Decode-side fields in, X-stage operand selectors, stall and stage occupancy out.
interface bypass_ctrl_if #(
   parameter int unsigned REG_BITS = 3,
   parameter int unsigned CNT_BITS = 16
);
   logic                d_valid;
   logic [REG_BITS-1:0] d_rs;
   logic [REG_BITS-1:0] d_rt;
   logic                d_rs_re;
   logic                d_rt_re;
   logic [REG_BITS-1:0] d_rd;
   logic                d_we;
   logic                d_is_load;
   logic                flush;
   logic                stall;
   logic [1:0]          x_sel_rs;
   logic [1:0]          x_sel_rt;
   logic                x_valid;
   logic                m_valid;
   logic                w_valid;
   logic [CNT_BITS-1:0] stall_cnt;

   modport master (
      output d_valid, d_rs, d_rt, d_rs_re, d_rt_re, d_rd, d_we, d_is_load, flush,
      input  stall, x_sel_rs, x_sel_rt, x_valid, m_valid, w_valid, stall_cnt
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_rs_re, d_rt_re, d_rd, d_we, d_is_load, flush,
      output stall, x_sel_rs, x_sel_rt, x_valid, m_valid, w_valid, stall_cnt
   );
endinterface

// File: rtl/bypass_ctrl.sv
// Forwarding selector and load-use interlock for the five-stage pipeline.
// Tracks destination records in X, M and W; selectors are registered into X.
module bypass_ctrl #(
   parameter int unsigned REG_BITS = 3,
   parameter int unsigned CNT_BITS = 16
) (
   input logic          clk,
   input logic          rst_n,
   bypass_ctrl_if.slave bus
);
   localparam int unsigned SEL_BITS = 2;

   typedef logic [SEL_BITS-1:0] sel_t;
   localparam sel_t SEL_RF = 2'b00;
   localparam sel_t SEL_M  = 2'b01;
   localparam sel_t SEL_W  = 2'b10;

   typedef struct packed {
      logic                valid;
      logic [REG_BITS-1:0] rd;
      logic                we;
      logic                is_load;
   } x_rec_t;

   // M only needs what a hit check reads; W only needs occupancy
   typedef struct packed {
      logic                valid;
      logic [REG_BITS-1:0] rd;
      logic                we;
   } m_rec_t;

   x_rec_t              x_q, x_d;
   m_rec_t              m_q;
   logic                w_valid_q;
   sel_t                sel_rs_q, sel_rs_d;
   sel_t                sel_rt_q, sel_rt_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   logic hit_x_rs, hit_x_rt, hit_m_rs, hit_m_rt;
   logic stall_c;

   function automatic logic hit(input logic                valid,
                                input logic                we,
                                input logic [REG_BITS-1:0] rd,
                                input logic [REG_BITS-1:0] src,
                                input logic                re);
      return valid & we & (rd == src) & re;
   endfunction

   always_comb begin
      hit_x_rs = hit(x_q.valid, x_q.we, x_q.rd, bus.d_rs, bus.d_rs_re);
      hit_x_rt = hit(x_q.valid, x_q.we, x_q.rd, bus.d_rt, bus.d_rt_re);
      hit_m_rs = hit(m_q.valid, m_q.we, m_q.rd, bus.d_rs, bus.d_rs_re);
      hit_m_rt = hit(m_q.valid, m_q.we, m_q.rd, bus.d_rt, bus.d_rt_re);
      stall_c  = bus.d_valid & x_q.is_load & (hit_x_rs | hit_x_rt) & ~bus.flush;
   end

   // Flush beats stall beats normal advance; bubbles always carry 00 selectors
   always_comb begin
      x_d      = '0;
      sel_rs_d = SEL_RF;
      sel_rt_d = SEL_RF;
      cnt_d    = cnt_q;
      if (bus.flush) begin
         x_d = '0;
      end else if (stall_c) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_BITS'(1);
         end
      end else if (bus.d_valid) begin
         x_d.valid   = 1'b1;
         x_d.rd      = bus.d_rd;
         x_d.we      = bus.d_we;
         x_d.is_load = bus.d_is_load;
         sel_rs_d    = hit_x_rs ? SEL_M : (hit_m_rs ? SEL_W : SEL_RF);
         sel_rt_d    = hit_x_rt ? SEL_M : (hit_m_rt ? SEL_W : SEL_RF);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         m_q       <= '0;
         w_valid_q <= 1'b0;
         sel_rs_q  <= SEL_RF;
         sel_rt_q  <= SEL_RF;
         cnt_q     <= '0;
      end else begin
         w_valid_q <= m_q.valid;
         m_q.valid <= x_q.valid;
         m_q.rd    <= x_q.rd;
         m_q.we    <= x_q.we;
         x_q       <= x_d;
         sel_rs_q  <= sel_rs_d;
         sel_rt_q  <= sel_rt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.stall     = stall_c;
   assign bus.x_sel_rs  = sel_rs_q;
   assign bus.x_sel_rt  = sel_rt_q;
   assign bus.x_valid   = x_q.valid;
   assign bus.m_valid   = m_q.valid;
   assign bus.w_valid   = w_valid_q;
   assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_bypass_ctrl.sv
// Directed bench for bypass_ctrl: per-step expectations queued at drive time,
// popped and checked once the instruction occupies X.
module tb_bypass_ctrl;
   localparam int unsigned REG_BITS = 3;
   localparam int unsigned CNT_BITS = 2;

   logic clk = 1'b0;
   logic rst_n;

   bypass_ctrl_if #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) bus ();

   bypass_ctrl #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic       xv;
      logic [1:0] srs;
      logic [1:0] srt;
      logic [1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic prev_xv = 1'b0;
   logic prev_mv = 1'b0;
   logic [1:0] exp_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".stall"},  16'(bus.stall),     16'h0);
      chk({tag, ".sel_rs"}, 16'(bus.x_sel_rs),  16'h0);
      chk({tag, ".sel_rt"}, 16'(bus.x_sel_rt),  16'h0);
      chk({tag, ".xv"},     16'(bus.x_valid),   16'h0);
      chk({tag, ".mv"},     16'(bus.m_valid),   16'h0);
      chk({tag, ".wv"},     16'(bus.w_valid),   16'h0);
      chk({tag, ".cnt"},    16'(bus.stall_cnt), 16'h0);
   endtask

   task automatic drive(input logic v, input logic [2:0] rs, input logic rs_re,
                        input logic [2:0] rt, input logic rt_re, input logic [2:0] rd,
                        input logic we, input logic ld, input logic fl);
      bus.d_valid   = v;
      bus.d_rs      = rs;
      bus.d_rs_re   = rs_re;
      bus.d_rt      = rt;
      bus.d_rt_re   = rt_re;
      bus.d_rd      = rd;
      bus.d_we      = we;
      bus.d_is_load = ld;
      bus.flush     = fl;
   endtask

   // Drive D for one cycle, check the combinational stall, then check X after the edge
   task automatic step(input string tag, input logic v, input logic [2:0] rs, input logic rs_re,
                       input logic [2:0] rt, input logic rt_re, input logic [2:0] rd,
                       input logic we, input logic ld, input logic fl, input logic e_stall,
                       input logic e_xv, input logic [1:0] e_srs, input logic [1:0] e_srt,
                       input logic [1:0] e_cnt);
      exp_t e;
      drive(v, rs, rs_re, rt, rt_re, rd, we, ld, fl);
      #1;
      chk({tag, ".stall"}, 16'(bus.stall), 16'(e_stall));
      sb.push_back('{tag, e_xv, e_srs, e_srt, e_cnt});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 16'h1, 16'h0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".xv"},     16'(bus.x_valid),   16'(e.xv));
         chk({e.tag, ".sel_rs"}, 16'(bus.x_sel_rs),  16'(e.srs));
         chk({e.tag, ".sel_rt"}, 16'(bus.x_sel_rt),  16'(e.srt));
         chk({e.tag, ".cnt"},    16'(bus.stall_cnt), 16'(e.cnt));
         chk({e.tag, ".mv"},     16'(bus.m_valid),   16'(prev_xv));
         chk({e.tag, ".wv"},     16'(bus.w_valid),   16'(prev_mv));
         prev_mv = prev_xv;
         prev_xv = e.xv;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) begin
         drive(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
               3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         @(posedge clk);
         #1;
         chk_all_zero("rst");
      end
      rst_n = 1'b1;

      //    tag          v  rs   re   rt   re   rd   we   ld   fl   stl  xv  srs    srt    cnt
      step("idle",      0, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
      step("add_r3",    1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);
      step("use_r3_x",  1, 3'd3, 1, 3'd1, 1, 3'd4, 1, 0, 0, 0, 1, 2'b01, 2'b00, 2'd0);
      step("add_r3b",   1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);
      step("unrel_r6",  1, 3'd3, 0, 3'd3, 0, 3'd6, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);
      step("use_r3_m",  1, 3'd3, 1, 3'd3, 0, 3'd0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'd0);
      step("w_r2a",     1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);
      step("w_r2b",     1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);
      step("rd_r2",     1, 3'd5, 1, 3'd2, 1, 3'd0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'd0);
      step("invalid",   0, 3'd2, 1, 3'd2, 1, 3'd2, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
      step("ldr_r5",    1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'd0);
      step("add55_stl", 1, 3'd5, 1, 3'd5, 1, 3'd7, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'd1);
      step("add55_go",  1, 3'd5, 1, 3'd5, 1, 3'd7, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'd1);
      step("ldr_r5b",   1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'd1);
      step("add55_fl",  1, 3'd5, 1, 3'd5, 1, 3'd7, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'd1);
      step("idle2",     0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd1);

      // Four more load-use stalls take the 2-bit counter past saturation
      exp_cnt = 2'd1;
      for (int i = 0; i < 4; i++) begin
         step("sat_ldr",  1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 0, 1, 2'b00, 2'b00, exp_cnt);
         exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
         step("sat_stl",  1, 3'd5, 1, 3'd1, 1, 3'd7, 0, 0, 0, 1, 0, 2'b00, 2'b00, exp_cnt);
         step("sat_go",   1, 3'd5, 1, 3'd1, 1, 3'd7, 0, 0, 0, 0, 1, 2'b10, 2'b00, exp_cnt);
      end

      // Reset mid-cycle while a load-use hazard is pending
      step("mid_ldr",   1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'd3);
      drive(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
      #1;
      chk("mid_pre.stall", 16'(bus.stall), 16'h1);
      chk("mid_pre.mv",    16'(bus.m_valid), 16'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      prev_xv = 1'b0;
      prev_mv = 1'b0;
      step("post_rst",  0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0);
      step("post_add",  1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
